// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg -- shared types and constants for the two-requester SRAM arbiter.
//   state_e   : access sequencer states (IDLE turnaround, WR, RD)
//   ADDR_W_DEF, DATA_W_DEF : default SRAM address / data widths
//   BURST_LEN : max consecutive locked grants to one requester (SRAM_ARB_LOCK_EN builds)
//   onehot2() : 1-bit requester index -> 2-bit one-hot vector
package sram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_e;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 32;
   localparam int BURST_LEN  = 4;

   function automatic logic [1:0] onehot2(input logic idx);
      return {idx, ~idx};
   endfunction

endpackage

// File: rtl/sram_arb_rr_arb2.sv
// rr_arb2 -- 2-way round-robin winner picker with optional burst-lock override.
// Optional feature macro: SRAM_ARB_LOCK_EN (lock override + burst counter).
// Ports:
//   clk, rst_  : clock, synchronous active-low reset
//   req [1:0]  : request vector
//   lock [1:0] : burst-lock hints (ignored unless SRAM_ARB_LOCK_EN)
//   take       : the current winner is being granted this cycle
//   win        : index of the selected requester (valid when any=1)
//   any        : at least one request is pending
module rr_arb2
   import sram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   input  logic       take,
   output logic       win,
   output logic       any
);

   // Index of the last granted requester; reset to 1 so requester 0 wins first.
   logic last_q, last_d;

   assign any = |req;

`ifdef SRAM_ARB_LOCK_EN
   localparam logic [2:0] BURST_MAX = 3'(BURST_LEN);

   // Consecutive grants to last_q in the current burst.
   logic [2:0] cnt_q, cnt_d;

   always_comb begin
      win = (&req) ? ~last_q : req[1];
      // Locked requester keeps the bus until its burst budget is spent.
      if (req[last_q] && lock[last_q] && (cnt_q < BURST_MAX)) begin
         win = last_q;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (take) begin
         if (win == last_q) begin
            cnt_d = (cnt_q == BURST_MAX) ? cnt_q : cnt_q + 3'd1;
         end else begin
            cnt_d = 3'd1;
         end
      end else if (!lock[last_q]) begin
         cnt_d = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         cnt_q <= 3'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic lock_unused;
   assign lock_unused = ^lock;

   always_comb begin
      win = (&req) ? ~last_q : req[1];
   end
`endif

   always_comb begin
      last_d = last_q;
      if (take) begin
         last_d = win;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/sram_arb.sv
// sram_arb -- arbitrates two requesters onto one asynchronous-strobe SRAM.
// Each access is one WR or RD cycle followed by one IDLE turnaround cycle.
// Optional feature macro: SRAM_ARB_LOCK_EN (burst lock, handled in rr_arb2).
// Ports:
//   clk, rst_          : clock, synchronous active-low reset
//   req/wr/lock [1:0]  : per-requester request, op (1=write), burst-lock hint
//   req_addr/req_wdata : per-requester address and write data
//   gnt [1:0]          : one-hot grant during the access cycle
//   rvalid [1:0]       : one-cycle read-data-valid pulse per requester
//   rdata              : last captured read data (shared)
//   addr, dat, rd_, wr_: SRAM address, bidirectional data, active-low strobes
module sram_arb
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_,
   input  logic [1:0]             req,
   input  logic [1:0]             wr,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   input  logic [1:0][DATA_W-1:0] req_wdata,
   input  logic [1:0]             lock,
   output logic [1:0]             gnt,
   output logic [1:0]             rvalid,
   output logic [DATA_W-1:0]      rdata,
   output logic [ADDR_W-1:0]      addr,
   inout  wire  [DATA_W-1:0]      dat,
   output logic                   rd_,
   output logic                   wr_
);

   state_e              state_q, state_d;
   logic                win_q, win_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rvalid_q, rvalid_d;

   logic win, any, take;

   // Winner only advances the round-robin pointer when actually granted.
   assign take = (state_q == IDLE) && any;

   rr_arb2 u_rr_arb2 (
      .clk  (clk),
      .rst_ (rst_),
      .req  (req),
      .lock (lock),
      .take (take),
      .win  (win),
      .any  (any)
   );

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rvalid_d = 2'b00;
      case (state_q)
         IDLE: begin
            if (any) begin
               // Latch the winner's command so later req changes cannot disturb it.
               state_d = wr[win] ? WR : RD;
               win_d   = win;
               addr_d  = req_addr[win];
               wdata_d = req_wdata[win];
            end
         end
         WR: begin
            state_d = IDLE;
         end
         RD: begin
            state_d         = IDLE;
            rdata_d         = dat;
            rvalid_d[win_q] = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q  <= IDLE;
         win_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign gnt    = (state_q == IDLE) ? 2'b00 : onehot2(win_q);
   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign addr   = addr_q;
   assign rd_    = (state_q != RD);
   assign wr_    = (state_q != WR);
   assign dat    = (state_q == WR) ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arb.sv
module tb_sram_arb;
   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_;
   logic [1:0]          req, wr, lock;
   logic [1:0][AW-1:0]  req_addr;
   logic [1:0][DW-1:0]  req_wdata;
   logic [1:0]          gnt, rvalid;
   logic [DW-1:0]       rdata;
   logic [AW-1:0]       addr;
   wire  [DW-1:0]       dat;
   logic                rd_, wr_;

   // Simple SRAM model: drives dat while rd_ is low, stores on posedge while wr_ is low.
   logic [DW-1:0] mem [0:(1<<AW)-1];
   assign dat = (rd_ === 1'b0) ? mem[addr] : {DW{1'bz}};
   always @(posedge clk) begin
      if (wr_ === 1'b0) mem[addr] <= dat;
   end

   sram_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .req       (req),
      .wr        (wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .lock      (lock),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .addr      (addr),
      .dat       (dat),
      .rd_       (rd_),
      .wr_       (wr_)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("[TB] check %s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp_g [4];
   logic [DW-1:0] zz;

   initial begin
      zz        = {DW{1'bz}};
      exp_g     = '{2'b01, 2'b10, 2'b01, 2'b10};
      rst_      = 1'b0;
      req       = 2'b00;
      wr        = 2'b00;
      lock      = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      tick();
      tick();
      // Reset state
      chk("rst_gnt",    gnt,    0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata",  rdata,  0);
      chk("rst_addr",   addr,   0);
      chk("rst_rd",     rd_,    1);
      chk("rst_wr",     wr_,    1);
      chk("rst_dat",    dat,    zz);
      rst_ = 1'b1;

      // Single write from requester 0
      req = 2'b01; wr = 2'b01; req_addr[0] = 10'h100; req_wdata[0] = 32'hAA;
      tick();
      chk("w_gnt",  gnt,  2'b01);
      chk("w_addr", addr, 10'h100);
      chk("w_dat",  dat,  32'hAA);
      chk("w_wr",   wr_,  0);
      chk("w_rd",   rd_,  1);
      req = 2'b00;
      tick();
      chk("w_idle_gnt",  gnt,  0);
      chk("w_idle_wr",   wr_,  1);
      chk("w_idle_dat",  dat,  zz);
      chk("w_idle_addr", addr, 10'h100);

      // Read-back by requester 1
      req = 2'b10; wr = 2'b00; req_addr[1] = 10'h100;
      tick();
      chk("r_gnt", gnt, 2'b10);
      chk("r_rd",  rd_, 0);
      chk("r_wr",  wr_, 1);
      req = 2'b00;
      tick();
      chk("r_rvalid", rvalid, 2'b10);
      chk("r_rdata",  rdata,  32'hAA);
      chk("r_rd_idle", rd_,   1);
      tick();
      chk("r_rvalid_end", rvalid, 0);
      chk("r_rdata_hold", rdata,  32'hAA);

      // Contention: both writing, grants alternate starting with 0 (1 granted last)
      req = 2'b11; wr = 2'b11;
      req_addr[0] = 10'h010; req_wdata[0] = 32'h11;
      req_addr[1] = 10'h020; req_wdata[1] = 32'h22;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("c_gnt", gnt, exp_g[i]);
         chk("c_wr",  wr_, 0);
         if (i == 3) req = 2'b00;
         tick();
         chk("c_idle", gnt, 0);
      end

      // Read 0x020 via requester 0
      req = 2'b01; wr = 2'b00; req_addr[0] = 10'h020;
      tick();
      chk("c_rd_gnt", gnt, 2'b01);
      req = 2'b00;
      tick();
      chk("c_rd_rvalid", rvalid, 2'b01);
      chk("c_rd_data",   rdata,  32'h22);

      // Reset in the middle of a read
      req = 2'b01; wr = 2'b00; req_addr[0] = 10'h010;
      tick();
      chk("mr_rd",   rd_,  0);
      chk("mr_addr", addr, 10'h010);
      rst_ = 1'b0; req = 2'b00;
      tick();
      chk("mr_gnt",    gnt,    0);
      chk("mr_rvalid", rvalid, 0);
      chk("mr_rdata",  rdata,  0);
      chk("mr_addr0",  addr,   0);
      chk("mr_rd1",    rd_,    1);
      chk("mr_wr1",    wr_,    1);
      chk("mr_dat",    dat,    zz);
      rst_ = 1'b1;
      tick();
      chk("mr_rvalid2", rvalid, 0);
      chk("mr_rdata2",  rdata,  0);

      // Request withdrawn before being sampled: no grant
      req = 2'b01;
      #2;
      req = 2'b00;
      tick();
      chk("glitch_gnt", gnt, 0);

      // Pointer reset: requester 0 wins first contention after reset
      req = 2'b11; wr = 2'b00; req_addr[0] = 10'h020; req_addr[1] = 10'h100;
      tick();
      chk("pr_gnt", gnt, 2'b01);
      req = 2'b00;
      tick();
      chk("pr_rvalid", rvalid, 2'b01);
      chk("pr_rdata",  rdata,  32'h22);

`ifdef SRAM_ARB_LOCK_EN
      // Burst lock: requester 0 keeps the bus for four grants, then requester 1
      rst_ = 1'b0;
      tick();
      rst_ = 1'b1;
      req = 2'b11; wr = 2'b11; lock = 2'b01;
      req_addr[1] = 10'h050; req_wdata[1] = 32'hB50;
      req_addr[0] = 10'h040; req_wdata[0] = 32'hA10;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("l_gnt",  gnt,  2'b01);
         chk("l_addr", addr, AW'(10'h040 + i));
         req_addr[0]  = AW'(10'h041 + i);
         req_wdata[0] = DW'(32'hA11 + i);
         tick();
         chk("l_idle", gnt, 0);
      end
      tick();
      chk("l_gnt1", gnt, 2'b10);
      req = 2'b00; lock = 2'b00;
      tick();
      for (int i = 0; i < 4; i++) begin
         req = 2'b01; wr = 2'b00; req_addr[0] = AW'(10'h040 + i);
         tick();
         req = 2'b00;
         tick();
         chk("l_rvalid", rvalid, 2'b01);
         chk("l_rdata",  rdata,  DW'(32'hA10 + i));
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Overall time limit so the bench always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, SRAM data width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst_  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req  input  [1:0]  per-requester access request.
REQ-006 SHALL have port wr  input  [1:0]  per-requester op: 1=write, 0=read.
REQ-007 SHALL have port req_addr  input  [1:0][ADDR_W-1:0]  per-requester word address.
REQ-008 SHALL have port req_wdata  input  [1:0][DATA_W-1:0]  per-requester write data.
REQ-009 SHALL have port lock  input  [1:0]  per-requester burst-lock hint (used only under SRAM_ARB_LOCK_EN).
REQ-010 SHALL have port gnt  output  [1:0]  one-hot grant; high during the SRAM access cycle.
REQ-011 SHALL have port rvalid  output  [1:0]  one-cycle pulse, read data valid for that requester.
REQ-012 SHALL have port rdata  output  DATA_W  last captured read data, shared by both requesters.
REQ-013 SHALL have port addr  output  ADDR_W  SRAM address.
REQ-014 SHALL have port dat  inout  DATA_W  SRAM data bus; driven only during writes, Z otherwise.
REQ-015 SHALL have port rd_  output  1  SRAM read strobe, active-low.
REQ-016 SHALL have port wr_  output  1  SRAM write strobe, active-low.

Function
REQ-017 SHALL implement states IDLE, WR, RD; every WR or RD cycle SHALL be followed by exactly one IDLE cycle (bus turnaround); peak rate is one access per 2 cycles.
REQ-018 In IDLE with any req bit set at a posedge, SHALL select a winner and enter WR (winner wr=1) or RD (wr=0) on that edge.
REQ-019 Arbitration SHALL be round-robin: with both requesting, the requester not granted last wins; after reset requester 0 has priority.
REQ-020 In WR/RD: gnt one-hot to the winner; addr = winner req_addr; WR drives dat = winner req_wdata with wr_=0; RD has rd_=0 and dat Z; the non-active strobe stays 1.
REQ-021 Requesters SHALL hold req/wr/req_addr/req_wdata stable until the cycle gnt is seen; the access completes at the posedge ending the WR/RD cycle.
REQ-022 RD SHALL capture dat into rdata at the posedge ending RD; rvalid for that requester SHALL pulse during the following (IDLE) cycle; rdata holds until the next read.
REQ-023 Write latency: req sampled at edge k -> wr_ low in cycle k..k+1; read latency: rvalid in cycle k+1..k+2.
REQ-024 A req deasserted before being sampled in IDLE SHALL produce no grant; req changes during WR/RD SHALL not affect the current access.
REQ-025 Outside WR/RD: gnt=0, rd_=1, wr_=1, dat=Z, addr holds its last value.

Reset
REQ-026 rst_ low at a posedge SHALL force IDLE regardless of state, aborting any access: gnt=0, rvalid=0, rdata=0, addr=0, rd_=1, wr_=1, dat=Z, last-grant pointer=1 (so requester 0 wins first), burst count=0.
REQ-027 The first access after rst_ deasserts SHALL be sampled no earlier than the first posedge with rst_ high.

Configuration
REQ-028 With SRAM_ARB_LOCK_EN defined: if the last winner still has req and lock set in IDLE, it SHALL win again regardless of round-robin, up to 4 consecutive grants (BURST_LEN), after which the other requester (if requesting) SHALL win; burst count resets when the other requester is granted or lock drops.
REQ-029 Without SRAM_ARB_LOCK_EN: lock SHALL be ignored and no burst counter built; pure round-robin.

Structure
REQ-030 Package sram_arb_pkg SHALL hold the state enum (IDLE, WR, RD), ADDR_W/DATA_W defaults and BURST_LEN=4.
REQ-031 Winner selection SHALL be the sub-module rr_arb2 (2-way round-robin picker with lock override), instantiated once.

Verification
REQ-032 Single write: req=01, wr=01, req_addr[0]=0x100, wdata=0xAA -> next cycle gnt=01, addr=0x100, dat=0xAA, wr_=0; following cycle all idle.
REQ-033 Read-back: req[1] read of 0x100 after REQ-032 -> rd_=0 one cycle, rvalid=10 next cycle, rdata=0xAA.
REQ-034 Contention: both req high continuously, lock=0 -> grants alternate 01,10,01,10 with one IDLE between each.
REQ-035 Lock (SRAM_ARB_LOCK_EN): req=11, lock=01 held, requester 0 writes 0x40..0x43 data 0xA10..0xA13 -> four consecutive grants to 0, then 10; reads return 0xA10..0xA13.
REQ-036 Reset mid-read: rst_ low during RD -> next cycle IDLE, rvalid never pulses, rdata=0, strobes high, dat Z.
